input_buffer_sequencer: RTL and testbench
=========================================

# input_buffer_sequencer

Control sequencer for the binarized-input `Input_Buffer`. For each frame it fills the buffer with `synopseFold` SIMD words from upstream. It then replays those words `neuronFold` times to the downstream matrix-vector unit, which reuses one input vector across all neuron folds. The block drives only the buffer's `enable`, `rwEn` and `address` pins; buffer data flows directly between upstream, buffer and consumer, and the sequencer supplies the handshakes around it.

## Interface
- `address_width`, 12: width of the buffer address.
- `synopseFold`, 18: words per input vector; legal range 1..2^address_width.
- `neuronFold`, 4: replay passes per frame; at least 1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `in_valid`  in  1  upstream word present on the buffer write-data bus.
- `in_ready`  out  1  sequencer accepts an upstream word this cycle.
- `out_ready`  in  1  consumer accepts the current buffer output word.
- `out_valid`  out  1  buffer read data valid.
- `out_last`  out  1  qualifies `out_valid`; marks the last word of a neuron-fold pass.
- `buf_enable`  out  1  buffer access strobe.
- `buf_rwEn`  out  1  1 = write, 0 = read; meaningful only when `buf_enable` = 1.
- `buf_address`  out  address_width  buffer address.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE: `start` moves to LOAD; `wr_cnt`, `rd_addr` and `fold_cnt` are cleared.
  - LOAD: upstream words are written to the buffer.
  - STREAM: buffer words are read and passed to the consumer.
  - DRAIN: waits for the final read word to be accepted.
- LOAD:
  - `in_ready` = 1, combinational from the state.
  - On `in_valid` && `in_ready`: `buf_enable` = 1, `buf_rwEn` = 1, `buf_address` = `wr_cnt`, then `wr_cnt` increments.
  - The handshake at `wr_cnt` == synopseFold-1 moves to STREAM.
  - With no handshake in a cycle, `buf_enable` = 0.
- STREAM issue rule: a read issues when (!`out_valid` || `out_ready`). On issue, `buf_enable` = 1, `buf_rwEn` = 0 and `buf_address` = `rd_addr`.
- STREAM counters:
  - `rd_addr` wraps synopseFold-1 → 0. On each wrap, `fold_cnt` increments.
  - Issuing at (`rd_addr` == synopseFold-1, `fold_cnt` == neuronFold-1) moves to DRAIN.
- Read pipeline:
  - `out_valid` and `out_last` are registered. On issue they load 1 and (`rd_addr` == synopseFold-1).
  - On an accept with no new issue, `out_valid` clears.
  - The buffer holds its read data while `buf_enable` = 0, so stalled data stays stable.
- DRAIN: no issues. Acceptance of the final word (`out_valid` && `out_ready`) moves to IDLE and asserts `done` for one cycle.
- `start` outside IDLE is ignored, and `in_valid` outside LOAD is ignored.
- Counter widths:
  - `wr_cnt` and `rd_addr`: address_width bits.
  - `fold_cnt`: max(1, clog2(neuronFold)) bits.
  - Compares are exact equality, with no overflow past the terminal values.
- Reset (`rst` low, any time, including mid-frame):
  - State returns to IDLE and all counters clear.
  - `in_ready`, `out_valid`, `out_last`, `buf_enable`, `buf_rwEn`, `busy` and `done` = 0; `buf_address` = 0.
  - Any partial frame is abandoned.

## Timing
- `buf_enable`, `buf_rwEn` and `buf_address` are combinational from state, counters and handshakes, and are valid in the access cycle.
- Buffer read latency is 1 cycle: data and `out_valid` appear in the cycle after the issue.
- `start` sampled high at edge k gives LOAD and `in_ready` = 1 from cycle k+1.
- The last write handshake at edge m puts the state in STREAM in cycle m+1; the first read issues in that cycle and `out_valid` = 1 in m+2.
- With `out_ready` held at 1, one word transfers per cycle with no bubbles. A frame then takes synopseFold + synopseFold·neuronFold + 2 cycles from `start` to `done`.
- `done` is asserted in the cycle after the final accept edge; `busy` falls in the same cycle.
- A new `start` is accepted in that same cycle.

## Test plan
- Reset mid-STREAM: assert `rst` low with synopseFold=18 → all outputs 0 and `buf_address` = 0 immediately; after release, a `start` runs a complete frame normally.
- Full-throughput frame (synopseFold=18, neuronFold=4, `in_valid` and `out_ready` held at 1):
  - 18 writes to addresses 0..17.
  - Then 72 reads, cycling addresses 0..17 four times.
  - `out_last` on output words 18, 36, 54 and 72.
  - `done` 92 cycles after `start`.
- Upstream gaps (synopseFold=3): toggle `in_valid` 1,0,1,0,1 → writes to addresses 0, 1, 2 only on the high cycles; STREAM entered after the third write.
- Consumer backpressure (synopseFold=3, neuronFold=2): drop `out_ready` for 3 cycles while `out_valid` = 1 → no new read issues, buffer data and `out_last` held stable, no word lost or duplicated; the read address sequence is exactly 0,1,2,0,1,2.
- Ignored `start`: pulse `start` during LOAD and during DRAIN → no restart, counters unaffected, single `done`.
- Edge parameters (synopseFold=1, neuronFold=1):
  - One write to address 0, then one read of address 0 with `out_last` = 1.
  - `done` 4 cycles after `start`.
  - `start` held high → frames run back-to-back.

Source files
------------

// File: rtl/input_buffer_sequencer_if.sv
// Handshake and buffer-control bundle for the input buffer sequencer.
// The sequencer sits on the slave side; the environment drives the master side.
interface input_buffer_sequencer_if #(
  parameter int address_width = 12
);
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_ready;
  logic                     out_valid;
  logic                     out_last;
  logic                     buf_enable;
  logic                     buf_rwEn;
  logic [address_width-1:0] buf_address;
  logic                     busy;
  logic                     done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, out_valid, out_last, buf_enable, buf_rwEn, buf_address, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, out_valid, out_last, buf_enable, buf_rwEn, buf_address, busy, done
  );
endinterface

// File: rtl/input_buffer_sequencer.sv
// Input buffer sequencer: loads synopseFold upstream words into the buffer,
// then replays them neuronFold times to the consumer. Only the buffer control
// pins and the handshakes are generated here; data bypasses this block.
module input_buffer_sequencer #(
  parameter int address_width = 12,
  parameter int synopseFold   = 18,
  parameter int neuronFold    = 4
) (
  input logic                     clk,
  input logic                     rst,
  input_buffer_sequencer_if.slave bus
);

  localparam int FOLD_W = (neuronFold > 1) ? $clog2(neuronFold) : 1;

  localparam logic [address_width-1:0] LAST_ADDR = address_width'(synopseFold - 1);
  localparam logic [FOLD_W-1:0]        LAST_FOLD = FOLD_W'(neuronFold - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]               r_state;
  logic [address_width-1:0] r_wr_cnt;
  logic [address_width-1:0] r_rd_addr;
  logic [FOLD_W-1:0]        r_fold_cnt;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_done;

  logic                     w_wr_fire;
  logic                     w_wr_last;
  logic                     w_rd_issue;
  logic                     w_rd_wrap;
  logic                     w_fold_last;
  logic                     w_accept;
  logic                     w_buf_enable;
  logic                     w_buf_rwEn;
  logic [address_width-1:0] w_buf_address;

  // Handshake decode and buffer access generation for the current cycle
  always_comb begin
    w_wr_fire     = (r_state == S_LOAD) && bus.in_valid;
    w_wr_last     = (r_wr_cnt == LAST_ADDR);
    // A read may issue when the output stage is empty or is being emptied now
    w_rd_issue    = (r_state == S_STREAM) && (!r_out_valid || bus.out_ready);
    w_rd_wrap     = (r_rd_addr == LAST_ADDR);
    w_fold_last   = (r_fold_cnt == LAST_FOLD);
    w_accept      = r_out_valid && bus.out_ready;
    w_buf_enable  = w_wr_fire || w_rd_issue;
    w_buf_rwEn    = w_wr_fire;
    w_buf_address = '0;
    if (w_wr_fire) begin
      w_buf_address = r_wr_cnt;
    end else if (w_rd_issue) begin
      w_buf_address = r_rd_addr;
    end
  end

  // Frame state machine and write/read/fold counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_rd_addr  <= '0;
      r_fold_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Counters are held clear so every frame starts from address 0
          r_wr_cnt   <= '0;
          r_rd_addr  <= '0;
          r_fold_cnt <= '0;
          if (bus.start) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_wr_fire) begin
            if (w_wr_last) begin
              r_state <= S_STREAM;
            end else begin
              r_wr_cnt <= r_wr_cnt + address_width'(1);
            end
          end
        end
        S_STREAM: begin
          if (w_rd_issue) begin
            if (w_rd_wrap) begin
              r_rd_addr <= '0;
              if (w_fold_last) begin
                r_state <= S_DRAIN;
              end else begin
                r_fold_cnt <= r_fold_cnt + FOLD_W'(1);
              end
            end else begin
              r_rd_addr <= r_rd_addr + address_width'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_accept) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output stage tracking the one-cycle buffer read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_rd_issue) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_rd_wrap;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Single-cycle completion pulse after the final word is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_accept;
    end
  end

  assign bus.in_ready    = (r_state == S_LOAD);
  assign bus.out_valid   = r_out_valid;
  assign bus.out_last    = r_out_last;
  assign bus.buf_enable  = w_buf_enable;
  assign bus.buf_rwEn    = w_buf_rwEn;
  assign bus.buf_address = w_buf_address;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;

endmodule

// File: tb/tb_input_buffer_sequencer.sv
// Directed bench for input_buffer_sequencer: three instances cover the
// 18x4, 3x2 and 1x1 fold configurations.
module tb_input_buffer_sequencer;

  localparam int AW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  input_buffer_sequencer_if #(.address_width(AW)) ifa ();
  input_buffer_sequencer_if #(.address_width(AW)) ifb ();
  input_buffer_sequencer_if #(.address_width(AW)) ifc ();

  input_buffer_sequencer #(.address_width(AW), .synopseFold(18), .neuronFold(4)) u_a (
    .clk(clk), .rst(rst_n), .bus(ifa)
  );
  input_buffer_sequencer #(.address_width(AW), .synopseFold(3), .neuronFold(2)) u_b (
    .clk(clk), .rst(rst_n), .bus(ifb)
  );
  input_buffer_sequencer #(.address_width(AW), .synopseFold(1), .neuronFold(1)) u_c (
    .clk(clk), .rst(rst_n), .bus(ifc)
  );

  always #5 clk = ~clk;

  // Access / transfer logs per instance, sampled mid-cycle
  int wr_a[$], rd_a[$], last_a[$];
  int wr_b[$], rd_b[$], last_b[$];
  int wr_c[$], rd_c[$], last_c[$];
  int acc_a = 0, acc_b = 0, acc_c = 0;
  int done_a = 0, done_b = 0, done_c = 0;

  always @(negedge clk) if (rst_n) begin
    if (ifa.buf_enable && ifa.buf_rwEn)  wr_a.push_back(int'(ifa.buf_address));
    if (ifa.buf_enable && !ifa.buf_rwEn) rd_a.push_back(int'(ifa.buf_address));
    if (ifa.out_valid && ifa.out_ready) begin
      acc_a++;
      if (ifa.out_last) last_a.push_back(acc_a);
    end
    if (ifa.done) done_a++;
  end

  always @(negedge clk) if (rst_n) begin
    if (ifb.buf_enable && ifb.buf_rwEn)  wr_b.push_back(int'(ifb.buf_address));
    if (ifb.buf_enable && !ifb.buf_rwEn) rd_b.push_back(int'(ifb.buf_address));
    if (ifb.out_valid && ifb.out_ready) begin
      acc_b++;
      if (ifb.out_last) last_b.push_back(acc_b);
    end
    if (ifb.done) done_b++;
  end

  always @(negedge clk) if (rst_n) begin
    if (ifc.buf_enable && ifc.buf_rwEn)  wr_c.push_back(int'(ifc.buf_address));
    if (ifc.buf_enable && !ifc.buf_rwEn) rd_c.push_back(int'(ifc.buf_address));
    if (ifc.out_valid && ifc.out_ready) begin
      acc_c++;
      if (ifc.out_last) last_c.push_back(acc_c);
    end
    if (ifc.done) done_c++;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic clear_logs();
    wr_a.delete(); rd_a.delete(); last_a.delete();
    wr_b.delete(); rd_b.delete(); last_b.delete();
    wr_c.delete(); rd_c.delete(); last_c.delete();
    acc_a = 0; acc_b = 0; acc_c = 0;
    done_a = 0; done_b = 0; done_c = 0;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return ifa.done;
      1:       return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       ifa.start = v;
      1:       ifb.start = v;
      default: ifc.start = v;
    endcase
  endtask

  // Called at posedge+1; start is sampled at the next edge
  task automatic start_frame(input int which);
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
  endtask

  // cyc counts cycles since the start-cycle; bounded by limit
  task automatic wait_done(input int which, input int limit, output int cyc);
    cyc = 1;
    while (!done_of(which) && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int guard;
    int wexp;
    int pat[5];
    pat = '{1, 0, 1, 0, 1};

    ifa.start = 0; ifa.in_valid = 0; ifa.out_ready = 0;
    ifb.start = 0; ifb.in_valid = 0; ifb.out_ready = 0;
    ifc.start = 0; ifc.in_valid = 0; ifc.out_ready = 0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check_vec("init_busy",   ifa.busy, 0);
    check_vec("init_ready",  ifa.in_ready, 0);
    check_vec("init_valid",  ifa.out_valid, 0);
    check_vec("init_addr",   ifa.buf_address, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-STREAM on the 18x4 instance
    ifa.in_valid = 1; ifa.out_ready = 1;
    start_frame(0);
    repeat (29) @(posedge clk); #1;
    check_vec("mid_stream_valid", ifa.out_valid, 1);
    check_vec("mid_stream_rd",    ifa.buf_enable && !ifa.buf_rwEn, 1);
    rst_n = 1'b0;
    #1;
    check_vec("rst_in_ready",  ifa.in_ready, 0);
    check_vec("rst_out_valid", ifa.out_valid, 0);
    check_vec("rst_out_last",  ifa.out_last, 0);
    check_vec("rst_buf_en",    ifa.buf_enable, 0);
    check_vec("rst_buf_rw",    ifa.buf_rwEn, 0);
    check_vec("rst_buf_addr",  ifa.buf_address, 0);
    check_vec("rst_busy",      ifa.busy, 0);
    check_vec("rst_done",      ifa.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-throughput frame after reset release
    clear_logs();
    start_frame(0);
    wait_done(0, 200, cyc);
    check_vec("a_done_latency", cyc, 92);
    check_vec("a_busy_at_done", ifa.busy, 0);
    check_vec("a_wr_count", wr_a.size(), 18);
    for (int i = 0; i < wr_a.size() && i < 18; i++)
      check_vec($sformatf("a_wr_addr%0d", i), wr_a[i], i);
    check_vec("a_rd_count", rd_a.size(), 72);
    for (int i = 0; i < rd_a.size() && i < 72; i++)
      check_vec($sformatf("a_rd_addr%0d", i), rd_a[i], i % 18);
    check_vec("a_accepts", acc_a, 72);
    check_vec("a_last_count", last_a.size(), 4);
    for (int i = 0; i < last_a.size() && i < 4; i++)
      check_vec($sformatf("a_last_pos%0d", i), last_a[i], 18 * (i + 1));
    @(posedge clk); #1;
    check_vec("a_done_pulse", ifa.done, 0);
    check_vec("a_done_count", done_a, 1);
    ifa.in_valid = 0; ifa.out_ready = 0;

    // Upstream gaps on the 3x2 instance
    clear_logs();
    ifb.out_ready = 1; ifb.in_valid = 0;
    start_frame(1);
    wexp = 0;
    for (int i = 0; i < 5; i++) begin
      ifb.in_valid = pat[i][0];
      #1;
      check_vec($sformatf("b_gap_en%0d", i), ifb.buf_enable, pat[i]);
      check_vec($sformatf("b_gap_rdy%0d", i), ifb.in_ready, 1);
      if (pat[i] != 0) begin
        check_vec($sformatf("b_gap_addr%0d", i), ifb.buf_address, wexp);
        wexp++;
      end
      @(posedge clk); #1;
    end
    ifb.in_valid = 0;
    #1;
    check_vec("b_gap_stream_rdy",  ifb.in_ready, 0);
    check_vec("b_gap_stream_rd",   ifb.buf_enable && !ifb.buf_rwEn, 1);
    check_vec("b_gap_stream_addr", ifb.buf_address, 0);
    wait_done(1, 50, cyc);
    check_vec("b_gap_done", ifb.done, 1);
    check_vec("b_gap_wr_count", wr_b.size(), 3);
    @(posedge clk); #1;

    // Consumer backpressure on the last word of the first pass
    clear_logs();
    ifb.in_valid = 1; ifb.out_ready = 1;
    start_frame(1);
    guard = 0;
    while (!(ifb.buf_enable && !ifb.buf_rwEn && ifb.buf_address == 2) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_vec("b_bp_found_issue", guard < 20, 1);
    @(posedge clk); #1;
    ifb.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_vec($sformatf("b_bp_valid%0d", k), ifb.out_valid, 1);
      check_vec($sformatf("b_bp_last%0d", k),  ifb.out_last, 1);
      check_vec($sformatf("b_bp_noissue%0d", k), ifb.buf_enable, 0);
      @(posedge clk); #1;
    end
    ifb.out_ready = 1;
    wait_done(1, 50, cyc);
    check_vec("b_bp_done", ifb.done, 1);
    check_vec("b_bp_rd_count", rd_b.size(), 6);
    for (int i = 0; i < rd_b.size() && i < 6; i++)
      check_vec($sformatf("b_bp_rd%0d", i), rd_b[i], i % 3);
    check_vec("b_bp_accepts", acc_b, 6);
    check_vec("b_bp_last_count", last_b.size(), 2);
    for (int i = 0; i < last_b.size() && i < 2; i++)
      check_vec($sformatf("b_bp_last_pos%0d", i), last_b[i], 3 * (i + 1));
    ifb.in_valid = 0;
    @(posedge clk); #1;

    // start ignored during LOAD and during DRAIN
    clear_logs();
    ifb.in_valid = 1; ifb.out_ready = 1;
    start_frame(1);
    ifb.start = 1;
    @(posedge clk); #1;
    ifb.start = 0;
    #1;
    check_vec("b_ign_load_addr", ifb.buf_address, 1);
    check_vec("b_ign_load_wr",   ifb.buf_rwEn, 1);
    guard = 0;
    while (!(ifb.busy && !ifb.in_ready && !ifb.buf_enable) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_vec("b_ign_found_drain", guard < 20, 1);
    ifb.out_ready = 0; ifb.start = 1;
    @(posedge clk); #1;
    ifb.start = 0;
    check_vec("b_ign_drain_busy", ifb.busy, 1);
    check_vec("b_ign_drain_done", ifb.done, 0);
    ifb.out_ready = 1;
    wait_done(1, 20, cyc);
    check_vec("b_ign_done", ifb.done, 1);
    repeat (3) @(posedge clk); #1;
    check_vec("b_ign_no_restart", ifb.busy, 0);
    check_vec("b_ign_done_count", done_b, 1);
    check_vec("b_ign_wr_count", wr_b.size(), 3);
    for (int i = 0; i < wr_b.size() && i < 3; i++)
      check_vec($sformatf("b_ign_wr%0d", i), wr_b[i], i);
    check_vec("b_ign_rd_count", rd_b.size(), 6);
    ifb.in_valid = 0;

    // Edge parameters: 1x1
    clear_logs();
    ifc.in_valid = 1; ifc.out_ready = 1;
    start_frame(2);
    wait_done(2, 20, cyc);
    check_vec("c_done_latency", cyc, 4);
    check_vec("c_wr_count", wr_c.size(), 1);
    if (wr_c.size() > 0) check_vec("c_wr_addr", wr_c[0], 0);
    check_vec("c_rd_count", rd_c.size(), 1);
    if (rd_c.size() > 0) check_vec("c_rd_addr", rd_c[0], 0);
    check_vec("c_last_count", last_c.size(), 1);
    if (last_c.size() > 0) check_vec("c_last_pos", last_c[0], 1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back frames with start held high
    clear_logs();
    ifc.start = 1;
    repeat (12) @(posedge clk); #1;
    ifc.start = 0;
    #6;
    check_vec("c_b2b_done_count", done_c, 3);
    check_vec("c_b2b_wr_count", wr_c.size(), 3);
    check_vec("c_b2b_accepts", acc_c, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
